// File: rtl/text_buf_ctrl_pkg.sv
// text_pkg: shared geometry, control-character codes and enums for the text buffer controller
package text_pkg;
  localparam int TXT_COLS = 16;
  localparam int TXT_ROWS = 16;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  typedef enum logic {IDLE, CLEAR} tb_state_t;
  typedef enum logic {GR_DIR, GR_STR} tb_grant_t;
endpackage

// File: rtl/text_buf_ctrl_if.sv
// text_buf_ctrl_if: direct-write (dir_valid/addr/data/ready) and byte-stream (str_valid/data/ready) handshakes; master drives, slave accepts
interface text_buf_ctrl_if;
  logic dir_valid;
  logic [7:0] dir_addr;
  logic [7:0] dir_data;
  logic dir_ready;
  logic str_valid;
  logic [7:0] str_data;
  logic str_ready;
  modport master(output dir_valid, dir_addr, dir_data, str_valid, str_data, input dir_ready, str_ready);
  modport slave(input dir_valid, dir_addr, dir_data, str_valid, str_data, output dir_ready, str_ready);
endinterface

// File: rtl/text_buf_ctrl_ram.sv
// text_ram: 256x8 buffer; ports clk65MHz, rst (read register only), we/waddr/wdata write, raddr in, rdata out one cycle later, read-first
module text_ram (
  input  logic       clk65MHz,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [256];
  always_ff @(posedge clk65MHz)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk65MHz)
    rdata <= rst ? 8'h00 : mem[raddr];
endmodule

// File: rtl/text_buf_ctrl.sv
// text_buf_ctrl: arbitrates clear/direct/stream writes into the 16x16 char buffer; ports clk65MHz, rst, char_xy->char_code, clear_req, bus (dir/str handshakes), cursor_xy, busy
module text_buf_ctrl
  import text_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic [7:0]       char_xy,
  output logic [7:0]       char_code,
  input  logic             clear_req,
  text_buf_ctrl_if.slave   bus,
  output logic [7:0]       cursor_xy,
  output logic             busy
);
  tb_state_t state, state_nxt;
  tb_grant_t last_grant;
  logic [7:0] clr_addr, cursor_nxt, waddr, wdata;
  logic clr_done, arb, dir_xfer, str_xfer, printable, is_cr, is_lf, is_bs, we;
  always_ff @(posedge clk65MHz)
    state <= rst ? (CLEAR_ON_RESET ? CLEAR : IDLE) : state_nxt;
  always_comb begin
    clr_done = state == CLEAR && clr_addr == 8'hFF;
    state_nxt = state == CLEAR ? (clr_done ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
  end
  always_comb begin
    busy = state == CLEAR;
    arb = state == IDLE && !clear_req;
    bus.dir_ready = arb && bus.dir_valid && (!bus.str_valid || last_grant == GR_STR);
    bus.str_ready = arb && bus.str_valid && (!bus.dir_valid || last_grant == GR_DIR);
    dir_xfer = bus.dir_valid && bus.dir_ready;
    str_xfer = bus.str_valid && bus.str_ready;
    printable = bus.str_data >= 8'h20 && bus.str_data <= 8'h7E;
    is_cr = bus.str_data == CH_CR;
    is_lf = bus.str_data == CH_LF;
    is_bs = bus.str_data == CH_BS;
    we = busy || dir_xfer || (str_xfer && (printable || is_bs));
    waddr = busy ? clr_addr : dir_xfer ? bus.dir_addr : printable ? cursor_xy : cursor_xy - 8'd1;
    wdata = busy ? CLEAR_CHAR : dir_xfer ? bus.dir_data : printable ? bus.str_data : CH_SPACE;
    cursor_nxt = clr_done ? 8'h00 :
                 !str_xfer ? cursor_xy :
                 printable ? cursor_xy + 8'd1 :
                 is_cr ? {cursor_xy[7:4], 4'h0} :
                 is_lf ? {cursor_xy[7:4] + 4'd1, 4'h0} :
                 is_bs ? cursor_xy - 8'd1 : cursor_xy;
  end
  always_ff @(posedge clk65MHz)
    if (rst) begin
      clr_addr <= 8'h00;
      cursor_xy <= 8'h00;
      last_grant <= GR_DIR;
    end else begin
      clr_addr <= busy ? clr_addr + 8'd1 : 8'h00;
      cursor_xy <= cursor_nxt;
      if (dir_xfer || str_xfer) last_grant <= dir_xfer ? GR_DIR : GR_STR;
    end
  text_ram u_ram (
    .clk65MHz(clk65MHz),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(char_xy),
    .rdata(char_code)
  );
endmodule

// File: tb/tb_text_buf_ctrl.sv
// tb_text_buf_ctrl: scoreboard bench with a behavioural buffer/cursor model and randomized traffic
module tb_text_buf_ctrl;
  import text_pkg::*;
  logic clk65MHz = 0;
  logic rst = 1;
  logic clear_req = 0;
  logic [7:0] char_xy = 0;
  logic [7:0] char_code, cursor_xy;
  logic busy;
  text_buf_ctrl_if bus();
  text_buf_ctrl dut (
    .clk65MHz(clk65MHz),
    .rst(rst),
    .char_xy(char_xy),
    .char_code(char_code),
    .clear_req(clear_req),
    .bus(bus),
    .cursor_xy(cursor_xy),
    .busy(busy)
  );
  always #5 clk65MHz = ~clk65MHz;
  int cyc = 0;
  always @(posedge clk65MHz) cyc <= cyc + 1;
  typedef struct {int due; bit dr; bit sr; bit bz; logic [7:0] cur;} hs_t;
  typedef struct {int due; logic [7:0] code;} rd_t;
  hs_t hs_q[$];
  rd_t rd_q[$];
  hs_t he;
  rd_t re;
  logic [7:0] m_mem [256];
  int m_clr = 0;
  logic [7:0] m_cur = 0;
  bit m_last_str = 0;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk65MHz) begin
    while (hs_q.size() > 0 && hs_q[0].due <= cyc) begin
      he = hs_q.pop_front();
      chk("hs_due", he.due, cyc);
      chk("dir_ready", int'(bus.dir_ready), int'(he.dr));
      chk("str_ready", int'(bus.str_ready), int'(he.sr));
      chk("busy", int'(busy), int'(he.bz));
      chk("cursor_xy", int'(cursor_xy), int'(he.cur));
    end
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      re = rd_q.pop_front();
      chk("rd_due", re.due, cyc);
      chk("char_code", int'(char_code), int'(re.code));
    end
  end
  task automatic do_reset(input int n);
    rst = 1;
    clear_req = 0;
    bus.dir_valid = 0;
    bus.str_valid = 0;
    repeat (n) begin
      @(posedge clk65MHz);
      #1;
      chk("rst_busy", int'(busy), 1);
      chk("rst_cursor", int'(cursor_xy), 0);
      chk("rst_code", int'(char_code), 0);
      chk("rst_ready", int'(bus.dir_ready | bus.str_ready), 0);
    end
    rst = 0;
    m_clr = 256;
    m_cur = 0;
    m_last_str = 0;
  endtask
  task automatic step(input bit clr, input bit dv, input logic [7:0] da, input logic [7:0] dd,
                      input bit sv, input logic [7:0] sd, input logic [7:0] xy);
    bit bz, dr, sr;
    clear_req = clr;
    bus.dir_valid = dv;
    bus.dir_addr = da;
    bus.dir_data = dd;
    bus.str_valid = sv;
    bus.str_data = sd;
    char_xy = xy;
    bz = m_clr > 0;
    dr = 0;
    sr = 0;
    if (!bz && !clr) begin
      if (dv && sv) begin
        sr = !m_last_str;
        dr = m_last_str;
      end else begin
        dr = dv;
        sr = sv;
      end
    end
    hs_q.push_back('{cyc, dr, sr, bz, m_cur});
    if (!bz) rd_q.push_back('{cyc + 1, m_mem[xy]});
    if (bz) begin
      m_clr--;
      if (m_clr == 0) begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h20;
        m_cur = 0;
      end
    end else if (clr) m_clr = 256;
    else if (dr) begin
      m_mem[da] = dd;
      m_last_str = 0;
    end else if (sr) begin
      m_last_str = 1;
      if (sd >= 8'h20 && sd <= 8'h7E) begin
        m_mem[m_cur] = sd;
        m_cur = m_cur + 8'd1;
      end else if (sd == CH_CR) m_cur = m_cur - m_cur % 16;
      else if (sd == CH_LF) m_cur = 8'(((m_cur / 16 + 1) % 16) * 16);
      else if (sd == CH_BS) begin
        m_cur = m_cur - 8'd1;
        m_mem[m_cur] = 8'h20;
      end
    end
    @(posedge clk65MHz);
    #1;
  endtask
  task automatic idle(input logic [7:0] xy);
    step(0, 0, 0, 0, 0, 0, xy);
  endtask
  task automatic sstep(input logic [7:0] b);
    step(0, 0, 0, 0, 1, b, 0);
  endtask
  task automatic full_clear();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300 && m_clr > 0; i++) idle(0);
  endtask
  initial begin
    bus.dir_valid = 0;
    bus.dir_addr = 0;
    bus.dir_data = 0;
    bus.str_valid = 0;
    bus.str_data = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    do_reset(3);
    for (int i = 0; i < 257; i++) idle(0);
    for (int i = 0; i < 256; i++) idle(8'(i));
    sstep(8'h41);
    sstep(8'h42);
    idle(8'h00);
    idle(8'h01);
    repeat (256) sstep(8'h43);
    idle(8'h01);
    idle(8'h00);
    full_clear();
    repeat (31) sstep(8'h78);
    sstep(CH_LF);
    repeat (5) sstep(8'h79);
    sstep(CH_CR);
    sstep(CH_BS);
    idle(8'h1F);
    idle(8'h20);
    full_clear();
    sstep(CH_BS);
    sstep(8'h07);
    idle(8'hFF);
    idle(8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h80 + i), 8'(8'h60 + i), 1, 8'h61, 8'(8'h80 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h90 + i), 8'(8'h70 + i), 0, 0, 8'(8'h90 + i));
    for (int i = 0; i < 4; i++) idle(8'(8'h90 + i));
    step(1, 1, 8'h00, 8'h11, 1, 8'h62, 0);
    for (int i = 1; i < 100; i++) step(0, 1, 8'h00, 8'h11, 1, 8'h62, 0);
    step(1, 1, 8'h00, 8'h11, 1, 8'h62, 0);
    for (int i = 0; i < 300 && m_clr > 0; i++) step(0, 1, 8'h00, 8'h11, 1, 8'h62, 0);
    idle(8'h33);
    step(0, 1, 8'h33, 8'h5A, 0, 0, 8'h33);
    idle(8'h33);
    idle(8'h33);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = r == 0 ? CH_CR : r == 1 ? CH_LF : r == 2 ? CH_BS : r == 3 ? 8'($urandom) : 8'($urandom_range(8'h20, 8'h7E));
      step($urandom_range(0, 399) == 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), b, 8'($urandom));
    end
    for (int i = 0; i < 300 && m_clr > 0; i++) idle(0);
    step(0, 1, 8'h44, 8'h99, 0, 0, 8'h44);
    step(0, 0, 0, 0, 0, 0, 8'h44);
    rst = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) idle(0);
    do_reset(2);
    for (int i = 0; i < 300 && m_clr > 0; i++) idle(0);
    for (int i = 0; i < 16; i++) idle(8'(i * 17));
    repeat (3) @(posedge clk65MHz);
    #1;
    chk("hs_q_empty", hs_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
